// File: rtl/t04_text_entry_buffer.sv
// Text entry buffer: turns keypad presses into an ASCII message.
// Numeric keys commit digits directly; alpha keys use multi-tap with an idle-timeout commit.
module t04_text_entry_buffer #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 25000000,
  parameter int LW      = $clog2(DEPTH+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               button,
  input  logic                     rising,
  input  logic [1:0]               app,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [7:0]               rd_char,
  output logic [LW-1:0]            len,
  output logic                     pending_valid,
  output logic [7:0]               pending_char,
  output logic                     msg_done,
  output logic                     locked,
  output logic                     overflow
);
  localparam int IW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_DONE} state_t;

  state_t          state, state_n;
  logic [3:0]      pkey, pkey_n;
  logic [1:0]      pidx, pidx_n;
  logic [TW-1:0]   timer, timer_n;
  logic            defer_v, defer_n;
  logic [7:0]      defer_ch, defer_ch_n;
  logic [1:0]      app_q;
  logic [7:0]      mem [DEPTH];

  logic            press, clr, bksp, msg_n, idle;
  logic            c0_v, c1_v, key_v;
  logic [7:0]      c0_ch, c1_ch, key_ch, tap_ch, pend_ch;
  logic [1:0]      last_idx;
  logic            w0, w1, ovf_n;
  logic [LW-1:0]   l1, l2, len_n;

  function automatic logic [7:0] first_letter(input logic [3:0] k);
    case (k)
      4'd2:    return 8'h41;
      4'd3:    return 8'h44;
      4'd4:    return 8'h47;
      4'd5:    return 8'h4A;
      4'd6:    return 8'h4D;
      4'd7:    return 8'h50;
      4'd8:    return 8'h54;
      default: return 8'h57;
    endcase
  endfunction

  assign press    = rising && !button[4] && !app[1];
  assign pend_ch  = first_letter(pkey) + {6'd0, pidx};
  assign last_idx = (pkey == 4'd7 || pkey == 4'd9) ? 2'd3 : 2'd2;

  // Ordering within one edge: deferred char, then timeout/mode-change flush,
  // then the press itself. At most two commits can land on a single edge.
  always_comb begin
    state_n = state; pkey_n = pkey; pidx_n = pidx; timer_n = '0;
    defer_n = 1'b0; defer_ch_n = defer_ch; msg_n = 1'b0; clr = 1'b0; bksp = 1'b0;
    c0_v = 1'b0; c0_ch = 8'h00; c1_v = 1'b0; c1_ch = 8'h00;
    key_v = 1'b0; key_ch = 8'h00; tap_ch = 8'h00; idle = 1'b1;
    if (press && button == 5'd15) begin
      clr = 1'b1;
    end else if (state != S_DONE) begin
      if (defer_v) begin
        c0_v = 1'b1; c0_ch = defer_ch;
      end
      if (state == S_PEND) begin
        if (timer == TW'(TIMEOUT-1) || app != app_q) begin
          c0_v = 1'b1; c0_ch = pend_ch; state_n = S_IDLE;
        end else begin
          idle = 1'b0; timer_n = timer + 1'b1;
        end
      end
      if (press) begin
        if (button == 5'd11) begin
          if (!idle) begin
            c0_v = 1'b1; c0_ch = pend_ch;
          end
          state_n = S_DONE; msg_n = 1'b1;
        end else if (button == 5'd10) begin
          if (!idle) state_n = S_IDLE;
          else       bksp = 1'b1;
        end else if (app == 2'b00) begin
          if (button < 5'd10) begin
            key_v = 1'b1; key_ch = 8'h30 + {4'h0, button[3:0]};
          end
        end else if (button <= 5'd1) begin
          tap_ch = button[0] ? 8'h2E : 8'h20;
          // a pending letter goes first; the punctuation follows one edge later
          if (!idle) begin
            c0_v = 1'b1; c0_ch = pend_ch; state_n = S_IDLE;
            defer_n = 1'b1; defer_ch_n = tap_ch;
          end else begin
            key_v = 1'b1; key_ch = tap_ch;
          end
        end else if (button <= 5'd9) begin
          state_n = S_PEND; timer_n = '0;
          if (!idle && button[3:0] == pkey) begin
            pidx_n = (pidx == last_idx) ? 2'd0 : pidx + 2'd1;
          end else begin
            if (!idle) begin
              c0_v = 1'b1; c0_ch = pend_ch;
            end
            pkey_n = button[3:0]; pidx_n = 2'd0;
          end
        end
      end
      if (key_v) begin
        if (c0_v) begin
          c1_v = 1'b1; c1_ch = key_ch;
        end else begin
          c0_v = 1'b1; c0_ch = key_ch;
        end
      end
    end
    if (state_n != S_PEND) timer_n = '0;
  end

  always_comb begin
    w0    = c0_v && (len < LW'(DEPTH));
    l1    = len + LW'(w0);
    w1    = c1_v && (l1 < LW'(DEPTH));
    l2    = l1 + LW'(w1);
    ovf_n = (c0_v && !w0) || (c1_v && !w1);
    len_n = (bksp && l2 != '0) ? l2 - 1'b1 : l2;
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      state    <= S_IDLE;
      pkey     <= 4'd0;
      pidx     <= 2'd0;
      timer    <= '0;
      defer_v  <= 1'b0;
      defer_ch <= 8'h00;
      len      <= '0;
      msg_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      pkey     <= pkey_n;
      pidx     <= pidx_n;
      timer    <= timer_n;
      defer_v  <= defer_n;
      defer_ch <= defer_ch_n;
      len      <= len_n;
      msg_done <= msg_n;
      overflow <= ovf_n;
    end
  end

  // Message storage is never cleared; len masks stale entries.
  always_ff @(posedge clk) begin
    app_q <= app;
    if (rst && !clr) begin
      if (w0) mem[IW'(len)] <= c0_ch;
      if (w1) mem[IW'(l1)]  <= c1_ch;
    end
  end

  assign rd_char       = (LW'(rd_idx) < len) ? mem[rd_idx] : 8'h20;
  assign pending_valid = (state == S_PEND);
  assign pending_char  = (state == S_PEND) ? pend_ch : 8'h00;
  assign locked        = (state == S_DONE);

endmodule

// File: tb/tb_t04_text_entry_buffer.sv
// Bench for t04_text_entry_buffer: directed plan steps, then random presses
// compared each cycle against a queue-based message model.
module tb_t04_text_entry_buffer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int LW      = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rising = 1'b0;
  logic [4:0]    button = 5'd0;
  logic [1:0]    app = 2'd0;
  logic [1:0]    rd_idx = 2'd0;
  logic [7:0]    rd_char, pending_char;
  logic [LW-1:0] len;
  logic          pending_valid, msg_done, locked, overflow;

  int errors = 0;
  int checks = 0;

  t04_text_entry_buffer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .button(button), .rising(rising), .app(app),
    .rd_idx(rd_idx), .rd_char(rd_char), .len(len),
    .pending_valid(pending_valid), .pending_char(pending_char),
    .msg_done(msg_done), .locked(locked), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: message as a queue, multi-tap as key + tap count.
  byte unsigned q[$];
  bit           m_pend, m_done, m_defer_v, e_md, e_ov;
  byte unsigned m_defer;
  int           m_key, m_tap, m_idle, app_prev;
  string        keys[10] = '{"", "", "ABC", "DEF", "GHI", "JKL", "MNO", "PQRS", "TUV", "WXYZ"};

  function automatic byte unsigned cur_letter();
    return keys[m_key][m_tap];
  endfunction

  function automatic void put(byte unsigned c);
    if (q.size() < DEPTH) q.push_back(c);
    else e_ov = 1'b1;
  endfunction

  function automatic logic [7:0] exp_rd(int i);
    return (i < q.size()) ? q[i] : 8'h20;
  endfunction

  task automatic model_edge(bit r_n, bit rise, int b, int a);
    bit pr;
    e_md = 1'b0; e_ov = 1'b0;
    pr = rise && b < 16 && a < 2;
    if (!r_n || (pr && b == 15)) begin
      q.delete(); m_pend = 0; m_done = 0; m_defer_v = 0; m_idle = 0;
    end else if (!m_done) begin
      if (m_defer_v) begin put(m_defer); m_defer_v = 0; end
      if (m_pend) begin
        if (m_idle == TIMEOUT-1 || a != app_prev) begin
          put(cur_letter()); m_pend = 0;
        end else m_idle++;
      end
      if (pr) begin
        if (b == 11) begin
          if (m_pend) put(cur_letter());
          m_pend = 0; m_done = 1; e_md = 1;
        end else if (b == 10) begin
          if (m_pend) m_pend = 0;
          else if (q.size() > 0) void'(q.pop_back());
        end else if (a == 0) begin
          if (b < 10) put(8'(8'h30 + b));
        end else if (b <= 1) begin
          if (m_pend) begin
            put(cur_letter()); m_pend = 0;
            m_defer = (b == 1) ? 8'h2E : 8'h20; m_defer_v = 1;
          end else put((b == 1) ? 8'h2E : 8'h20);
        end else if (b <= 9) begin
          if (m_pend && b == m_key) m_tap = (m_tap + 1) % keys[b].len();
          else begin
            if (m_pend) put(cur_letter());
            m_key = b; m_tap = 0; m_pend = 1;
          end
          m_idle = 0;
        end
      end
    end
    app_prev = a;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(bit r_n, bit rise, int b, int a);
    rst = r_n; rising = rise; button = 5'(b); app = 2'(a);
    rd_idx = 2'($urandom_range(0, DEPTH-1));
    @(posedge clk);
    model_edge(r_n, rise, b, a);
    #1;
    chk("len", 32'(len), q.size());
    chk("pending_valid", 32'(pending_valid), 32'(m_pend));
    chk("pending_char", 32'(pending_char), m_pend ? 32'(cur_letter()) : 0);
    chk("msg_done", 32'(msg_done), 32'(e_md));
    chk("locked", 32'(locked), 32'(m_done));
    chk("overflow", 32'(overflow), 32'(e_ov));
    chk("rd_char", 32'(rd_char), 32'(exp_rd(int'(rd_idx))));
  endtask

  task automatic rd(int i, logic [7:0] exp, string tag);
    rd_idx = 2'(i);
    #1;
    chk(tag, 32'(rd_char), 32'(exp));
  endtask

  initial begin
    string taps = "PQRSP";
    int a, b, sel;
    bit r, rise;

    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    chk("rst_len", 32'(len), 0);
    chk("rst_pv", 32'(pending_valid), 0);
    chk("rst_locked", 32'(locked), 0);

    // numeric entry and completion
    tick(1, 1, 4, 0); tick(1, 0, 0, 0); tick(1, 1, 2, 0); tick(1, 0, 0, 0);
    tick(1, 1, 11, 0);
    chk("num_done", 32'(msg_done), 1);
    chk("num_locked", 32'(locked), 1);
    chk("num_len", 32'(len), 2);
    rd(0, 8'h34, "num_rd0"); rd(1, 8'h32, "num_rd1"); rd(2, 8'h20, "num_rd2");
    tick(1, 0, 0, 0);
    chk("done_pulse", 32'(msg_done), 0);
    tick(1, 1, 5, 0);
    chk("done_ignore", 32'(len), 2);
    tick(1, 1, 15, 0);
    chk("clr_locked", 32'(locked), 0);
    chk("clr_len", 32'(len), 0);

    // multi-tap wrap and timeout commit
    tick(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      tick(1, 1, 7, 1);
      chk("tap", 32'(pending_char), 32'(taps[i]));
      if (i < 4) tick(1, 0, 0, 1);
    end
    repeat (7) tick(1, 0, 0, 1);
    chk("pre_to_len", 32'(len), 0);
    chk("pre_to_pv", 32'(pending_valid), 1);
    tick(1, 0, 0, 1);
    chk("to_len", 32'(len), 1);
    chk("to_pv", 32'(pending_valid), 0);
    rd(0, 8'h50, "to_rd0");

    // key change commit, star discard and backspace
    tick(1, 1, 15, 1);
    tick(1, 1, 2, 1); tick(1, 1, 3, 1);
    chk("chg_len", 32'(len), 1);
    chk("chg_pc", 32'(pending_char), 8'h44);
    rd(0, 8'h41, "chg_rd0");
    tick(1, 1, 10, 1);
    chk("star_pv", 32'(pending_valid), 0);
    chk("star_len", 32'(len), 1);
    tick(1, 1, 10, 1);
    chk("bksp_len", 32'(len), 0);

    // press landing on the timeout edge
    tick(1, 1, 2, 1); tick(1, 1, 2, 1);
    repeat (7) tick(1, 0, 0, 1);
    tick(1, 1, 2, 1);
    chk("race_len", 32'(len), 1);
    chk("race_pc", 32'(pending_char), 8'h41);
    rd(0, 8'h42, "race_rd0");

    // '1' with a pending letter: two commits on consecutive edges
    tick(1, 1, 1, 1);
    chk("dot_len1", 32'(len), 2);
    rd(1, 8'h41, "dot_rd1");
    tick(1, 0, 0, 1);
    chk("dot_len2", 32'(len), 3);
    rd(2, 8'h2E, "dot_rd2");

    // reset mid-entry
    tick(1, 1, 5, 1);
    chk("mid_pv", 32'(pending_valid), 1);
    tick(0, 0, 0, 1);
    chk("mid_len", 32'(len), 0);
    chk("mid_pv0", 32'(pending_valid), 0);
    chk("mid_md", 32'(msg_done), 0);

    // fill to capacity, back-to-back presses
    tick(1, 0, 0, 0);
    repeat (4) tick(1, 1, 1, 0);
    chk("full_len", 32'(len), 4);
    chk("full_ovf0", 32'(overflow), 0);
    tick(1, 1, 1, 0);
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_len", 32'(len), 4);
    tick(1, 0, 0, 0);
    chk("ovf_end", 32'(overflow), 0);
    tick(1, 1, 11, 0);
    tick(1, 1, 15, 0);
    chk("d_len", 32'(len), 0);
    chk("d_locked", 32'(locked), 0);

    // mode change flushes; locked mode ignores even D
    tick(1, 1, 4, 1);
    tick(1, 0, 0, 2);
    chk("mode_len", 32'(len), 1);
    rd(0, 8'h47, "mode_rd0");
    tick(1, 1, 15, 2);
    chk("lock_d", 32'(len), 1);

    a = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 1;
      r    = ($urandom_range(0, 199) != 0);
      rise = ($urandom_range(0, 3) == 0);
      sel  = $urandom_range(0, 29);
      if (sel < 2)      b = 15;
      else if (sel < 4) b = $urandom_range(12, 31);
      else              b = $urandom_range(0, 11);
      tick(r, rise, b, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
